// File: rtl/conf_int_mul_idct_sched.sv
// Frame sequencer for the IDCT approximate-multiplier wrapper: LOAD -> ROW -> COL -> DRAIN.
// All outputs registered (controls take effect one cycle after the decision); stalls via in_valid insert bubbles.
module conf_int_mul_idct_sched #(
  parameter int LOAD_CNT = 64,
  parameter int NUM_OPS  = 64,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       abort,
  input  logic       cfg_apx_row,
  input  logic       cfg_apx_col,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] state_o,
  output logic [8:0] count0,
  output logic       racc_o,
  output logic       rapx_o,
  output logic       rstP_o,
  output logic       res_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_LOAD  = 3'b001;
  localparam logic [2:0] S_ROW   = 3'b010;
  localparam logic [2:0] S_COL   = 3'b011;
  localparam logic [2:0] S_DRAIN = 3'b100;

  localparam logic [8:0] LOAD_LAST  = 9'(LOAD_CNT - 1);
  localparam logic [8:0] OPS_LAST   = 9'(NUM_OPS - 1);
  localparam logic [8:0] DRAIN_LAST = 9'(PIPE_LAT - 1);

  logic [2:0]          state_nxt;
  logic [8:0]          cnt_nxt;
  logic                done_nxt;
  logic                hs;
  logic                issue;
  logic                cfg_row_q;
  logic                cfg_col_q;
  logic [PIPE_LAT-1:0] pipe_q;

  assign hs        = in_valid & in_ready;
  assign issue     = hs & ((state_o == S_ROW) | (state_o == S_COL));
  assign res_valid = pipe_q[PIPE_LAT-1];

  always_comb begin
    state_nxt = state_o;
    cnt_nxt   = count0;
    done_nxt  = 1'b0;
    case (state_o)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cnt_nxt   = 9'd0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (count0 == LOAD_LAST) begin
            state_nxt = S_ROW;
            cnt_nxt   = 9'd0;
          end else begin
            cnt_nxt = count0 + 9'd1;
          end
        end
      end
      S_ROW, S_COL: begin
        if (hs) begin
          if (count0 == OPS_LAST) begin
            state_nxt = (state_o == S_ROW) ? S_COL : S_DRAIN;
            cnt_nxt   = 9'd0;
          end else begin
            cnt_nxt = count0 + 9'd1;
          end
        end
      end
      S_DRAIN: begin
        if (count0 == DRAIN_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 9'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = count0 + 9'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 9'd0;
      end
    endcase
    // abort overrides every transition, including a start in IDLE
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 9'd0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_o   <= S_IDLE;
      count0    <= 9'd0;
      in_ready  <= 1'b0;
      racc_o    <= 1'b1;
      rapx_o    <= 1'b0;
      rstP_o    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_row_q <= 1'b0;
      cfg_col_q <= 1'b0;
      pipe_q    <= '0;
    end else begin
      state_o  <= state_nxt;
      count0   <= cnt_nxt;
      done     <= done_nxt;
      busy     <= (state_nxt != S_IDLE);
      in_ready <= (state_nxt == S_LOAD) | (state_nxt == S_ROW) | (state_nxt == S_COL);
      racc_o   <= (state_nxt == S_IDLE);
      rstP_o   <= (state_nxt == S_IDLE) | (state_nxt == S_LOAD);
      case (state_nxt)
        S_ROW:          rapx_o <= cfg_row_q;
        S_COL, S_DRAIN: rapx_o <= cfg_col_q;
        default:        rapx_o <= 1'b0;
      endcase
      if ((state_o == S_IDLE) && start && !abort) begin
        cfg_row_q <= cfg_apx_row;
        cfg_col_q <= cfg_apx_col;
      end
      // in-flight products are dropped on abort rather than reported
      if (abort) pipe_q <= '0;
      else       pipe_q <= (pipe_q << 1) | PIPE_LAT'(issue);
    end
  end

endmodule

// File: tb/tb_conf_int_mul_idct_sched.sv
// Directed bench for conf_int_mul_idct_sched with a res_valid scoreboard keyed by expected cycle.
module tb_conf_int_mul_idct_sched;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_LOAD  = 3'b001;
  localparam logic [2:0] S_ROW   = 3'b010;
  localparam logic [2:0] S_COL   = 3'b011;
  localparam logic [2:0] S_DRAIN = 3'b100;

  logic       clk = 1'b0;
  logic       rstN, start, abort, cfg_apx_row, cfg_apx_col, in_valid;
  logic       in_ready, racc_o, rapx_o, rstP_o, res_valid, busy, done;
  logic [2:0] state_o;
  logic [8:0] count0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int res_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  conf_int_mul_idct_sched dut (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort),
    .cfg_apx_row(cfg_apx_row), .cfg_apx_col(cfg_apx_col),
    .in_valid(in_valid), .in_ready(in_ready), .state_o(state_o), .count0(count0),
    .racc_o(racc_o), .rapx_o(rapx_o), .rstP_o(rstP_o), .res_valid(res_valid),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and score res_valid every cycle.
  task automatic step();
    logic want;
    @(posedge clk);
    #1;
    cyc++;
    want = (exp_q.size() != 0) && (exp_q[0] == cyc);
    if (want) void'(exp_q.pop_front());
    chk("res_valid_timing", 32'(res_valid), 32'(want));
    if (res_valid === 1'b1) res_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic purge_after(input int last);
    while (exp_q.size() != 0 && exp_q[$] > last) void'(exp_q.pop_back());
  endtask

  // One frame. cut_k>0 aborts (or resets) in the cycle of the cut_k-th handshake.
  task automatic run_frame(input logic row, input logic col, input bit toggle,
                           input int cut_k, input bit cut_rst, input bit poke);
    int c0, k, t, w, d0, r0;
    logic [2:0] ph;
    logic [8:0] ec;
    d0 = done_cnt;
    r0 = res_cnt;
    c0 = cyc;
    start = 1'b1;
    cfg_apx_row = row;
    cfg_apx_col = col;
    step();
    start = 1'b0;
    cfg_apx_row = ~row;
    cfg_apx_col = ~col;
    chk("start_state", 32'(state_o), 32'(S_LOAD));
    chk("start_busy", 32'(busy), 32'd1);
    k = 0;
    t = 0;
    while (k < 192 && t < 1000) begin
      in_valid = toggle ? ((t % 2) == 0) : 1'b1;
      start = poke && (k == 150);
      if (in_valid) begin
        k++;
        if (k <= 64) begin
          ph = S_LOAD; ec = 9'(k - 1);
        end else if (k <= 128) begin
          ph = S_ROW;  ec = 9'(k - 65);
        end else begin
          ph = S_COL;  ec = 9'(k - 129);
        end
        chk("phase", 32'(state_o), 32'(ph));
        chk("count0", 32'(count0), 32'(ec));
        chk("in_ready", 32'(in_ready), 32'd1);
        if (ph == S_LOAD) begin
          chk("rstP_load", 32'(rstP_o), 32'd1);
          chk("racc_load", 32'(racc_o), 32'd0);
        end else begin
          chk("rapx_issue", 32'(rapx_o), 32'((ph == S_ROW) ? row : col));
          chk("rstP_issue", 32'(rstP_o), 32'd0);
          exp_q.push_back(cyc + 2);
        end
        if (k == cut_k) begin
          if (cut_rst) rstN = 1'b0;
          else         abort = 1'b1;
          purge_after(cyc);
          step();
          rstN = 1'b1;
          abort = 1'b0;
          in_valid = 1'b0;
          if (cut_rst)
            chk("rst_outputs",
                32'({state_o, count0, in_ready, racc_o, rapx_o, rstP_o, res_valid, busy, done}),
                32'({3'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
          else
            chk("abort_outputs", 32'({state_o, count0, racc_o, res_valid, busy, done}),
                32'({3'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
          repeat (6) step();
          chk("no_done_after_cut", 32'(done_cnt - d0), 32'd0);
          chk("idle_after_cut", 32'(state_o), 32'(S_IDLE));
          chk("sb_empty_after_cut", 32'(exp_q.size()), 32'd0);
          return;
        end
      end
      step();
      t++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("handshakes", 32'(k), 32'd192);
    chk("drain_state", 32'(state_o), 32'(S_DRAIN));
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (!toggle) chk("done_latency", 32'(cyc - c0), 32'd195);
    step();
    chk("done_width", 32'(done), 32'd0);
    chk("idle_state", 32'(state_o), 32'(S_IDLE));
    chk("idle_racc", 32'(racc_o), 32'd1);
    chk("res_pulses", 32'(res_cnt - r0), 32'd128);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_apx_row = 1'b0;
    cfg_apx_col = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    rstN = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_idle", 32'({state_o, count0, in_ready, racc_o, rstP_o, busy, done}),
          32'({3'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    end

    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    // abort at ROW count0=10, then a clean restart
    run_frame(1'b1, 1'b1, 1'b0, 75, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // start during COL is ignored; start+abort in IDLE stays IDLE
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_state", 32'(state_o), 32'(S_IDLE));
    chk("start_abort_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("start_abort_hold", 32'(state_o), 32'(S_IDLE));

    // reset pulse at COL count0=30, then recovery
    run_frame(1'b0, 1'b1, 1'b0, 159, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
